// File: rtl/cable_timer_unit.sv
// Enable/end handshake responder timing the accumulation, line and gear intervals on one prescaled tick counter.
// Optional CABLE_TMR_LOAD_EN adds runtime-writable durations (ld_en/ld_sel/ld_val).
module cable_timer_unit #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PRESCALE   = 1000,
    parameter int unsigned ACC_TICKS  = 50,
    parameter int unsigned LINE_TICKS = 200,
    parameter int unsigned GEAR_TICKS = 120
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en_acc,
    input  logic             en_line_timer,
    input  logic             en_gear_timer,
    input  logic             detect,
`ifdef CABLE_TMR_LOAD_EN
    input  logic             ld_en,
    input  logic [1:0]       ld_sel,
    input  logic [CNT_W-1:0] ld_val,
`endif
    output logic             ready,
    output logic             line_end,
    output logic             gear_end,
    output logic             busy,
    output logic             conflict,
    output logic [CNT_W-1:0] tick_cnt
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ACC, S_LINE, S_GEAR, S_EXPIRED} state_t;
    typedef enum logic [1:0] {OWN_ACC, OWN_LINE, OWN_GEAR} owner_t;

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [CNT_W-1:0] dur_acc, dur_line, dur_gear;
    logic             own_en, tick;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [CNT_W-1:0] eff_dur(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

`ifdef CABLE_TMR_LOAD_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dur_acc  <= CNT_W'(ACC_TICKS);
            dur_line <= CNT_W'(LINE_TICKS);
            dur_gear <= CNT_W'(GEAR_TICKS);
        end else if (ld_en) begin
            case (ld_sel)
                2'd0:    dur_acc  <= ld_val;
                2'd1:    dur_line <= ld_val;
                2'd2:    dur_gear <= ld_val;
                default: ;
            endcase
        end
    end
`else
    always_comb begin
        dur_acc  = CNT_W'(ACC_TICKS);
        dur_line = CNT_W'(LINE_TICKS);
        dur_gear = CNT_W'(GEAR_TICKS);
    end
`endif

    always_comb begin
        case (owner_q)
            OWN_LINE: own_en = en_line_timer;
            OWN_GEAR: own_en = en_gear_timer;
            default:  own_en = en_acc;
        endcase
        tick    = (presc_q == PW'(PRESCALE - 1));
        cnt_inc = (&tick_cnt) ? tick_cnt : tick_cnt + CNT_W'(1);
    end

    // The interval length is latched at entry so a runtime write only affects the next run.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        presc_d = presc_q;
        cnt_d   = tick_cnt;
        dur_d   = dur_q;
        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                cnt_d   = '0;
                if (en_line_timer) begin
                    state_d = S_LINE;
                    owner_d = OWN_LINE;
                    dur_d   = eff_dur(dur_line);
                end else if (en_gear_timer) begin
                    state_d = S_GEAR;
                    owner_d = OWN_GEAR;
                    dur_d   = eff_dur(dur_gear);
                end else if (en_acc) begin
                    state_d = S_ACC;
                    owner_d = OWN_ACC;
                    dur_d   = eff_dur(dur_acc);
                end
            end
            S_ACC, S_LINE, S_GEAR: begin
                if (!own_en) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    cnt_d   = '0;
                end else if (state_q == S_ACC && detect) begin
                    presc_d = '0;
                    cnt_d   = '0;
                end else if (tick) begin
                    presc_d = '0;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == dur_q) state_d = S_EXPIRED;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_EXPIRED: begin
                if (!own_en) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_ACC;
            presc_q  <= '0;
            tick_cnt <= '0;
            dur_q    <= CNT_W'(1);
            ready    <= 1'b0;
            line_end <= 1'b0;
            gear_end <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            presc_q  <= presc_d;
            tick_cnt <= cnt_d;
            dur_q    <= dur_d;
            ready    <= (state_d == S_ACC);
            line_end <= (state_d == S_EXPIRED) && (owner_d == OWN_LINE);
            gear_end <= (state_d == S_EXPIRED) && (owner_d == OWN_GEAR);
            busy     <= (state_d == S_ACC) || (state_d == S_LINE) || (state_d == S_GEAR);
            conflict <= ({1'b0, en_acc} + {1'b0, en_line_timer} + {1'b0, en_gear_timer}) > 2'd1;
        end
    end

endmodule

// File: tb/tb_cable_timer_unit.sv
// Randomized self-checking bench for cable_timer_unit against an elapsed-cycle reference model.
// Define CABLE_TMR_LOAD_EN to also exercise runtime duration writes.
module tb_cable_timer_unit;

    localparam int P    = 4;
    localparam int ACC  = 2;
    localparam int LINE = 3;
    localparam int GEAR = 5;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          en_acc, en_line_timer, en_gear_timer, detect;
`ifdef CABLE_TMR_LOAD_EN
    logic          ld_en;
    logic [1:0]    ld_sel;
    logic [CW-1:0] ld_val;
`endif
    logic          ready, line_end, gear_end, busy, conflict;
    logic [CW-1:0] tick_cnt;

    cable_timer_unit #(
        .CNT_W(CW), .PRESCALE(P), .ACC_TICKS(ACC), .LINE_TICKS(LINE), .GEAR_TICKS(GEAR)
    ) dut (
        .clk(clk), .resetn(resetn),
        .en_acc(en_acc), .en_line_timer(en_line_timer), .en_gear_timer(en_gear_timer),
        .detect(detect),
`ifdef CABLE_TMR_LOAD_EN
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_val(ld_val),
`endif
        .ready(ready), .line_end(line_end), .gear_end(gear_end),
        .busy(busy), .conflict(conflict), .tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: mode 0=idle 1=running 2=expired; own 0=acc 1=line 2=gear; el = cycles since (re)start
    int m_mode, m_own, m_el, m_n, m_conf;
    int m_dur[3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_own = 0; m_el = 0; m_n = 0; m_conf = 0;
        m_dur[0] = ACC; m_dur[1] = LINE; m_dur[2] = GEAR;
    endtask

    task automatic model_edge();
        int own_en;
        m_conf = ((int'(en_acc) + int'(en_line_timer) + int'(en_gear_timer)) > 1) ? 1 : 0;
        if (m_mode == 0) begin
            if (en_line_timer || en_gear_timer || en_acc) begin
                m_own  = en_line_timer ? 1 : (en_gear_timer ? 2 : 0);
                m_mode = 1;
                m_el   = 0;
                m_n    = eff(m_dur[m_own]);
            end
        end else begin
            own_en = (m_own == 1) ? int'(en_line_timer) : (m_own == 2) ? int'(en_gear_timer) : int'(en_acc);
            if (own_en == 0) m_mode = 0;
            else if (m_mode == 1) begin
                if (m_own == 0 && detect) m_el = 0;
                else begin
                    m_el++;
                    if (m_el == m_n * P) m_mode = 2;
                end
            end
        end
`ifdef CABLE_TMR_LOAD_EN
        if (ld_en && ld_sel != 2'd3) m_dur[ld_sel] = int'(ld_val);
`endif
    endtask

    task automatic check_outputs();
        int exp_cnt;
        exp_cnt = (m_mode == 0) ? 0 : (m_mode == 2) ? m_n : m_el / P;
        check_eq("ready",    32'(ready),    32'(m_mode == 1 && m_own == 0));
        check_eq("busy",     32'(busy),     32'(m_mode == 1));
        check_eq("line_end", 32'(line_end), 32'(m_mode == 2 && m_own == 1));
        check_eq("gear_end", 32'(gear_end), 32'(m_mode == 2 && m_own == 2));
        check_eq("conflict", 32'(conflict), 32'(m_conf));
        check_eq("tick_cnt", 32'(tick_cnt), 32'(exp_cnt));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (resetn) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic a, input logic l, input logic g, input logic d);
        en_acc = a; en_line_timer = l; en_gear_timer = g; detect = d;
    endtask

    initial begin
        resetn = 1'b0;
        drive(1, 1, 1, 0);
`ifdef CABLE_TMR_LOAD_EN
        ld_en = 1'b0; ld_sel = '0; ld_val = '0;
`endif
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_outputs();
        end
        resetn = 1'b1;
        cycle();
        check_eq("line_after_reset", 32'(busy), 32'd1);
        drive(0, 0, 0, 0);
        repeat (2) cycle();

        // line interval: end held, then cleared after drop
        drive(0, 1, 0, 0);
        repeat (16) cycle();
        check_eq("line_end_held", 32'(line_end), 32'd1);
        drive(0, 0, 0, 0);
        repeat (2) cycle();

        // accumulation with retrigger
        drive(1, 0, 0, 0);
        repeat (6) cycle();
        drive(1, 0, 0, 1);
        cycle();
        drive(1, 0, 0, 0);
        repeat (12) cycle();
        drive(0, 0, 0, 0);
        repeat (2) cycle();

        // gear abort mid-count
        drive(0, 0, 1, 0);
        repeat (10) cycle();
        drive(0, 0, 0, 0);
        cycle();
        check_eq("gear_abort_cnt", 32'(tick_cnt), 32'd0);
        repeat (2) cycle();

        // simultaneous enables: line wins
        drive(1, 1, 0, 0);
        repeat (3) cycle();
        check_eq("conflict_set", 32'(conflict), 32'd1);
        drive(0, 0, 0, 0);
        repeat (2) cycle();

`ifdef CABLE_TMR_LOAD_EN
        drive(0, 1, 0, 0);
        repeat (5) cycle();
        ld_en = 1'b1; ld_sel = 2'd1; ld_val = 16'd1;
        cycle();
        ld_en = 1'b0;
        repeat (8) cycle();
        check_eq("ld_old_run_end", 32'(line_end), 32'd1);
        drive(0, 0, 0, 0);
        repeat (2) cycle();
        drive(0, 1, 0, 0);
        repeat (6) cycle();
        check_eq("ld_new_run_end", 32'(line_end), 32'd1);
        drive(0, 0, 0, 0);
        repeat (2) cycle();
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) en_acc = ~en_acc;
            if ($urandom_range(0, 14) == 0) en_line_timer = ~en_line_timer;
            if ($urandom_range(0, 14) == 0) en_gear_timer = ~en_gear_timer;
            detect = ($urandom_range(0, 7) == 0);
`ifdef CABLE_TMR_LOAD_EN
            ld_en  = ($urandom_range(0, 19) == 0);
            ld_sel = 2'($urandom_range(0, 3));
            ld_val = CW'($urandom_range(0, 6));
`endif
            cycle();
            if ($urandom_range(0, 499) == 0) begin
                #2 resetn = 1'b0;
                #1 model_reset();
                check_outputs();
                @(negedge clk);
                check_outputs();
                resetn = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
